mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single byte-wide program/data memory (16-bit byte address, 8-bit write data, combinational read, write on rising clock edge) between two requesters: port A (CPU load/store/fetch) and port B (DMA/loader). Grants one requester at a time by round-robin and sequences each 8- or 16-bit access as one or two byte cycles, little-endian. The block sits between the requesters and the memory; it is the memory's only driver.

## Interface
Parameters:
- none; widths are fixed by the 16-bit address space and 8-bit memory.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `a_req` / `b_req` in 1: the requester asks for an access; held high until its ack.
- `a_we` / `b_we` in 1: 1 = write, 0 = read.
- `a_word` / `b_word` in 1: 1 = 16-bit access, 0 = 8-bit access.
- `a_addr` / `b_addr` in 16: byte address.
- `a_wdata` / `b_wdata` in 16: write data; a byte write uses [7:0].
- `a_ack` / `b_ack` out 1: one-cycle completion pulse.
- `a_rdata` / `b_rdata` out 16: read result, valid while the port's ack is high and held until that port's next read.
- `mem_addr` out 16: memory address.
- `mem_din` out 8: memory write data.
- `mem_read` out 1: memory read enable.
- `mem_write` out 1: memory write enable.
- `mem_dout` in 16: memory read data; only [7:0] is used, and only while `mem_read` is high.

## Operation
- States:
  - IDLE: evaluates requests.
  - LO: low-byte cycle at addr.
  - HI: high-byte cycle at addr+1.
  - ACK: completion cycle.
- Grant:
  - In IDLE, a single request is granted.
  - If both ports request, the port not granted last wins.
  - `last` resets to B, so A wins the first tie.
  - The granted port's we/word/addr/wdata are latched on the grant edge.
- Transitions:
  - IDLE→LO on any request.
  - LO→HI if word, else LO→ACK.
  - HI→ACK.
  - ACK→IDLE unconditionally.
- Memory drive is decoded from registered state and latched request; it is zero in IDLE and ACK.
  - LO: `mem_addr` = addr; write drives `mem_din` = wdata[7:0] with `mem_write`=1; read drives `mem_read`=1 and captures `mem_dout[7:0]` into rdata[7:0] at the end of the cycle.
  - HI: `mem_addr` = addr+1, modulo 2^16 (0xFFFF wraps to 0x0000); write uses wdata[15:8]; a read captures into rdata[15:8].
  - A byte read sets rdata[15:8] = 0x00.
  - Writes leave rdata unchanged.
- ACK: pulses the granted port's ack only.
  - Requests are not sampled in ACK. A requester that still holds req in the following IDLE starts a new transaction, which is how back-to-back accesses are made.
- Requester inputs that change while a request is in flight are ignored (they were latched at grant). Dropping req before ack does not abort the transaction; the ack is still issued.
- Reset, including mid-transaction:
  - State goes to IDLE, `last`=B, all acks and memory enables go to 0, `mem_addr`/`mem_din` to 0, both rdata to 0.
  - No ack is issued for the aborted transaction.
  - A low byte already written stays written, so a torn word write is permitted.

## Timing
- Request seen in IDLE at cycle N (grant edge at the end of N):
  - Byte access: LO at N+1, ack at N+2.
  - Word access: LO at N+1, HI at N+2, ack at N+3.
- Minimum request-to-request spacing per port: 3 cycles (byte) / 4 cycles (word).
- With both ports continuously requesting, grants strictly alternate.
- Read capture relies on the memory's combinational read settling within LO/HI.
- Writes commit on the rising edge that ends LO/HI.

## Structure
- Shared package `srp16_mem_pkg`:
  - state encoding (IDLE, LO, HI, ACK),
  - port IDs PORT_A/PORT_B,
  - constant BYTE_W=8 and ADDR_W=16.
- One sub-module, `mem_rr_grant`: a two-way round-robin grant with `last` register, inputs a_req/b_req/advance, outputs one-hot grant.
- The sequencer FSM and datapath latches live in the top module.

## Test plan
- Byte write A addr 0x1234 data 0x00AB, then byte read → mem_write only in LO at 0x1234 with din 0xAB; ack at N+2; a_rdata=0x00AB.
- Word write B addr 0x2000 data 0xBEEF, then word read → bytes 0xEF@0x2000, 0xBE@0x2001; b_rdata=0xBEEF; ack at N+3.
- Word read at 0xFFFF → HI cycle mem_addr=0x0000; rdata = {mem[0x0000], mem[0xFFFF]}.
- A and B request simultaneously and continuously from reset → grants A,B,A,B; each ack pulses exactly one cycle on the correct port only.
- rst_n asserted during HI of a word write at 0x3000 → mem[0x3000] updated, mem[0x3001] unchanged; no ack; all outputs 0; after release, the first tie goes to A.

Source files
------------

// File: rtl/srp16_mem_pkg.sv
// Shared definitions for the byte-wide memory port arbiter: widths,
// sequencer state encoding and requester port identifiers.
package srp16_mem_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Address of the high byte of a word; wraps 0xFFFF to 0x0000.
    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
        return a + 16'd1;
    endfunction

endpackage

// File: rtl/mem_rr_grant.sv
// Two-way round-robin grant. On a tie the port not granted last wins;
// the last-granted record only moves when the sequencer accepts a grant.
module mem_rr_grant
    import srp16_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic       b_req,
    input  logic       advance,
    output logic [1:0] grant
);

    port_e last_q;
    port_e last_d;

    // One-hot grant decode, bit 0 = port A, bit 1 = port B.
    always_comb begin
        grant = 2'b00;
        if (a_req && b_req) begin
            if (last_q == PORT_B) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else if (a_req) begin
            grant = 2'b01;
        end else if (b_req) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

    // Next value of the last-granted record.
    always_comb begin
        last_d = last_q;
        if (advance && grant[0]) begin
            last_d = PORT_A;
        end else if (advance && grant[1]) begin
            last_d = PORT_B;
        end else begin
            last_d = last_q;
        end
    end

    // Last-granted register; starts at B so A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two requesters onto one byte-wide memory and sequences each
// 8/16-bit access as one or two little-endian byte cycles.
module mem_port_arbiter
    import srp16_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic        a_word,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_ack,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic        b_word,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic [15:0] b_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [15:0] mem_dout
);

    state_e      state_q, state_d;
    port_e       port_q, port_d;
    logic        we_q, we_d;
    logic        word_q, word_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] a_rdata_q, a_rdata_d;
    logic [15:0] b_rdata_q, b_rdata_d;
    logic [15:0] cap_s;
    logic [1:0]  grant_s;
    logic        advance_s;
    logic        unused_dout_hi_s;

    assign unused_dout_hi_s = ^mem_dout[15:8];
    assign advance_s        = (state_q == ST_IDLE);

    mem_rr_grant u_grant (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_req   (a_req),
        .b_req   (b_req),
        .advance (advance_s),
        .grant   (grant_s)
    );

    // Sequencer next state and request latching on the grant edge.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        we_d    = we_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s[0]) begin
                    state_d = ST_LO;
                    port_d  = PORT_A;
                    we_d    = a_we;
                    word_d  = a_word;
                    addr_d  = a_addr;
                    wdata_d = a_wdata;
                end else if (grant_s[1]) begin
                    state_d = ST_LO;
                    port_d  = PORT_B;
                    we_d    = b_we;
                    word_d  = b_word;
                    addr_d  = b_addr;
                    wdata_d = b_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LO: begin
                if (word_q) begin
                    state_d = ST_HI;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_HI:   state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory drive, decoded from the registered state and latched request.
    always_comb begin
        mem_addr  = 16'h0000;
        mem_din   = 8'h00;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            ST_LO: begin
                mem_addr  = addr_q;
                mem_din   = we_q ? wdata_q[7:0] : 8'h00;
                mem_write = we_q;
                mem_read  = ~we_q;
            end
            ST_HI: begin
                mem_addr  = addr_next(addr_q);
                mem_din   = we_q ? wdata_q[15:8] : 8'h00;
                mem_write = we_q;
                mem_read  = ~we_q;
            end
            default: begin
                mem_addr  = 16'h0000;
                mem_din   = 8'h00;
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

    // Read-data capture into the owning port; a byte read zeroes the high byte.
    always_comb begin
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        cap_s     = (port_q == PORT_A) ? a_rdata_q : b_rdata_q;
        if (state_q == ST_LO && !we_q) begin
            cap_s = word_q ? {cap_s[15:8], mem_dout[7:0]} : {8'h00, mem_dout[7:0]};
        end else if (state_q == ST_HI && !we_q) begin
            cap_s = {mem_dout[7:0], cap_s[7:0]};
        end else begin
            cap_s = cap_s;
        end
        if (port_q == PORT_A) begin
            a_rdata_d = cap_s;
        end else begin
            b_rdata_d = cap_s;
        end
    end

    // State, latched request and read-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            port_q    <= PORT_A;
            we_q      <= 1'b0;
            word_q    <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            a_rdata_q <= 16'h0000;
            b_rdata_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            we_q      <= we_d;
            word_q    <= word_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_ack   = (state_q == ST_ACK) && (port_q == PORT_A);
    assign b_ack   = (state_q == ST_ACK) && (port_q == PORT_B);
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, a_word, b_req, b_we, b_word;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, b_ack, mem_read, mem_write;
    logic [15:0] a_rdata, b_rdata, mem_addr, mem_dout;
    logic [7:0]  mem_din;

    logic [7:0]  mem [0:65535];
    logic        pl_we;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Upper byte is junk on purpose: the arbiter must ignore it.
    assign mem_dout = {8'hA5, mem[mem_addr]};

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_din;
        else if (pl_we) mem[pl_addr] <= pl_data;
    end

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_word(a_word), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_word(b_word), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
        .mem_write(mem_write), .mem_dout(mem_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] addr, input logic [7:0] data);
        pl_we = 1'b1; pl_addr = addr; pl_data = data;
        step();
        pl_we = 1'b0;
    endtask

    task automatic set_a(input logic req, input logic we, input logic word,
                         input logic [15:0] addr, input logic [15:0] wdata);
        a_req = req; a_we = we; a_word = word; a_addr = addr; a_wdata = wdata;
    endtask

    task automatic set_b(input logic req, input logic we, input logic word,
                         input logic [15:0] addr, input logic [15:0] wdata);
        b_req = req; b_we = we; b_word = word; b_addr = addr; b_wdata = wdata;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_ack"}, {31'd0, a_ack}, 32'd0);
        chk({tag, "_b_ack"}, {31'd0, b_ack}, 32'd0);
        chk({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
        chk({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
        chk({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_din"}, {24'd0, mem_din}, 32'd0);
        chk({tag, "_a_rdata"}, {16'd0, a_rdata}, 32'd0);
        chk({tag, "_b_rdata"}, {16'd0, b_rdata}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        pl_we = 1'b0; pl_addr = 16'h0000; pl_data = 8'h00;
        set_a(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_b(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step();
        step();
        chk_all_zero("reset");
        preload(16'h1235, 8'h77);
        preload(16'hFFFF, 8'h11);
        preload(16'h0000, 8'h22);
        preload(16'h3000, 8'h00);
        preload(16'h3001, 8'h99);
        rst_n = 1'b1;
        step();

        // Byte write A; req dropped during LO must not cancel the ack.
        set_a(1'b1, 1'b1, 1'b0, 16'h1234, 16'h00AB);
        chk("bw_idle_write", {31'd0, mem_write}, 32'd0);
        step();
        chk("bw_lo_write", {31'd0, mem_write}, 32'd1);
        chk("bw_lo_read", {31'd0, mem_read}, 32'd0);
        chk("bw_lo_addr", {16'd0, mem_addr}, 32'h1234);
        chk("bw_lo_din", {24'd0, mem_din}, 32'hAB);
        chk("bw_lo_ack", {31'd0, a_ack}, 32'd0);
        a_req = 1'b0;
        step();
        chk("bw_ack_a", {31'd0, a_ack}, 32'd1);
        chk("bw_ack_b", {31'd0, b_ack}, 32'd0);
        chk("bw_ack_write", {31'd0, mem_write}, 32'd0);
        chk("bw_mem_lo", {24'd0, mem[16'h1234]}, 32'hAB);
        chk("bw_mem_next", {24'd0, mem[16'h1235]}, 32'h77);
        step();
        chk("bw_idle_ack", {31'd0, a_ack}, 32'd0);

        // Byte read A; high byte must read as zero despite mem[0x1235]=0x77.
        set_a(1'b1, 1'b0, 1'b0, 16'h1234, 16'hFFFF);
        step();
        chk("br_lo_read", {31'd0, mem_read}, 32'd1);
        chk("br_lo_write", {31'd0, mem_write}, 32'd0);
        chk("br_lo_addr", {16'd0, mem_addr}, 32'h1234);
        set_a(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        step();
        chk("br_ack_a", {31'd0, a_ack}, 32'd1);
        chk("br_rdata", {16'd0, a_rdata}, 32'h00AB);
        step();
        chk("br_ack_drop", {31'd0, a_ack}, 32'd0);
        chk("br_rdata_hold", {16'd0, a_rdata}, 32'h00AB);

        // Word write B, little-endian, ack at N+3.
        set_b(1'b1, 1'b1, 1'b1, 16'h2000, 16'hBEEF);
        step();
        chk("ww_lo_addr", {16'd0, mem_addr}, 32'h2000);
        chk("ww_lo_din", {24'd0, mem_din}, 32'hEF);
        chk("ww_lo_write", {31'd0, mem_write}, 32'd1);
        step();
        chk("ww_hi_addr", {16'd0, mem_addr}, 32'h2001);
        chk("ww_hi_din", {24'd0, mem_din}, 32'hBE);
        chk("ww_hi_write", {31'd0, mem_write}, 32'd1);
        chk("ww_hi_ack", {31'd0, b_ack}, 32'd0);
        b_req = 1'b0;
        step();
        chk("ww_ack_b", {31'd0, b_ack}, 32'd1);
        chk("ww_ack_a", {31'd0, a_ack}, 32'd0);
        chk("ww_mem_lo", {24'd0, mem[16'h2000]}, 32'hEF);
        chk("ww_mem_hi", {24'd0, mem[16'h2001]}, 32'hBE);
        step();

        // Word read B.
        set_b(1'b1, 1'b0, 1'b1, 16'h2000, 16'h0000);
        step();
        chk("wr_lo_read", {31'd0, mem_read}, 32'd1);
        step();
        chk("wr_hi_read", {31'd0, mem_read}, 32'd1);
        chk("wr_hi_addr", {16'd0, mem_addr}, 32'h2001);
        b_req = 1'b0;
        step();
        chk("wr_ack_b", {31'd0, b_ack}, 32'd1);
        chk("wr_rdata", {16'd0, b_rdata}, 32'hBEEF);
        chk("wr_a_rdata_kept", {16'd0, a_rdata}, 32'h00AB);
        step();

        // Word read A across the top of the address space.
        set_a(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
        step();
        chk("wrap_lo_addr", {16'd0, mem_addr}, 32'hFFFF);
        step();
        chk("wrap_hi_addr", {16'd0, mem_addr}, 32'h0000);
        chk("wrap_hi_read", {31'd0, mem_read}, 32'd1);
        a_req = 1'b0;
        step();
        chk("wrap_ack", {31'd0, a_ack}, 32'd1);
        chk("wrap_rdata", {16'd0, a_rdata}, 32'h2211);
        step();

        // Reset during HI of a word write: low byte lands, high byte does not.
        set_a(1'b1, 1'b1, 1'b1, 16'h3000, 16'h5566);
        step();
        step();
        chk("torn_hi_addr", {16'd0, mem_addr}, 32'h3001);
        chk("torn_hi_write", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        chk("torn_mem_lo", {24'd0, mem[16'h3000]}, 32'h66);
        chk("torn_mem_hi", {24'd0, mem[16'h3001]}, 32'h99);
        a_req = 1'b0;
        step();
        step();
        chk("torn_no_ack", {31'd0, a_ack}, 32'd0);
        chk("torn_mem_hi_after", {24'd0, mem[16'h3001]}, 32'h99);

        // Both ports request continuously from reset release: A,B,A,B.
        set_a(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
        set_b(1'b1, 1'b0, 1'b0, 16'h2000, 16'h0000);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk($sformatf("tie_a_ack_c%0d", i), {31'd0, a_ack},
                ((i == 2) || (i == 8)) ? 32'd1 : 32'd0);
            chk($sformatf("tie_b_ack_c%0d", i), {31'd0, b_ack},
                ((i == 5) || (i == 11)) ? 32'd1 : 32'd0);
            if (i == 2) chk("tie_a_rdata", {16'd0, a_rdata}, 32'h00AB);
            if (i == 5) chk("tie_b_rdata", {16'd0, b_rdata}, 32'h00EF);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
